// File: rtl/elastic_buffer_read_ctrl_pkg.sv
// Shared definitions for the RX elastic buffer: SKP symbol, default watermarks,
// controller encodings and the pointer gray-code helpers used by both clock domains.
package elastic_buffer_pkg;

    localparam logic [8:0] SKP_SYM         = 9'h11C;
    localparam int         DEFAULT_HALF    = 8;
    localparam int         DEFAULT_LOW_WM  = 6;
    localparam int         DEFAULT_HIGH_WM = 10;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One decision per read cycle; priority between the RUN rules is resolved
    // before this value is formed, so downstream logic never sees two at once.
    typedef enum logic [2:0] {
        ACT_WAIT      = 3'd0,
        ACT_START     = 3'd1,
        ACT_UNDERFLOW = 3'd2,
        ACT_OVERFLOW  = 3'd3,
        ACT_INSERT    = 3'd4,
        ACT_DELETE    = 3'd5,
        ACT_READ      = 3'd6
    } action_t;

    function automatic logic [31:0] gray_to_bin(input logic [31:0] i_gray);
        logic [31:0] v_bin;
        for (int i = 0; i < 32; i++) begin
            v_bin[i] = ^(i_gray >> i);
        end
        return v_bin;
    endfunction

    function automatic logic [31:0] bin_to_gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/elastic_buffer_read_ctrl_gray_to_binary.sv
// Combinational gray-to-binary converter for an n+1 bit buffer pointer.
module gray_to_binary
    import elastic_buffer_pkg::*;
#(
    parameter int n = 4
)
(
    input  logic [n:0] i_gray,
    output logic [n:0] o_bin
);

    // Each binary bit is the XOR of all gray bits at or above its position.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i <= n; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/elastic_buffer_read_ctrl.sv
// Read-side controller of the RX elastic buffer: fills to half, then reads one
// symbol per cycle while inserting/deleting SKP symbols to hold occupancy centred.
module elastic_buffer_read_ctrl
    import elastic_buffer_pkg::*;
#(
    parameter int n       = 4,
    parameter int DATA_W  = 9,
    parameter int HALF    = DEFAULT_HALF,
    parameter int LOW_WM  = DEFAULT_LOW_WM,
    parameter int HIGH_WM = DEFAULT_HIGH_WM
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [n:0]        gray_counter_write_sync,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [n-1:0]      mem_rd_addr,
    output logic [n:0]        gray_counter_read,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              skp_added,
    output logic              skp_removed,
    output logic              overflow,
    output logic              underflow
);

    localparam int                PW       = n + 1;
    localparam logic [PW-1:0]     FULL_OCC = PW'(2 ** n);
    localparam logic [PW-1:0]     HALF_OCC = PW'(HALF);
    localparam logic [PW-1:0]     LOW_OCC  = PW'(LOW_WM);
    localparam logic [PW-1:0]     HIGH_OCC = PW'(HIGH_WM);
    localparam logic [DATA_W-1:0] SKP      = DATA_W'(SKP_SYM);

    state_t              r_state;
    logic [PW-1:0]       r_rd_bin;
    logic                r_adj_done;
    logic [PW-1:0]       r_gray_rd;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_skp_added;
    logic                r_skp_removed;
    logic                r_overflow;
    logic                r_underflow;

    logic [PW-1:0]       w_wr_bin;
    logic [PW-1:0]       w_occ;
    logic                w_is_skp;
    action_t             w_action;
    logic [PW-1:0]       w_rd_bin_next;
    logic [PW-1:0]       w_rd_gray_next;

    gray_to_binary #(
        .n(n)
    ) u_wr_g2b (
        .i_gray(gray_counter_write_sync),
        .o_bin (w_wr_bin)
    );

    // Pointers carry one extra wrap bit, so full (2^n) and empty (0) stay distinct.
    assign w_occ    = w_wr_bin - r_rd_bin;
    assign w_is_skp = (mem_rd_data == SKP);

    always_comb begin
        w_action = ACT_WAIT;
        if (r_state == ST_FILL) begin
            if (w_occ >= HALF_OCC) begin
                w_action = ACT_START;
            end
        end else if (w_occ == '0) begin
            w_action = ACT_UNDERFLOW;
        end else if (w_occ == FULL_OCC) begin
            w_action = ACT_OVERFLOW;
        end else if (w_is_skp && !r_adj_done && (w_occ < LOW_OCC)) begin
            w_action = ACT_INSERT;
        end else if (w_is_skp && !r_adj_done && (w_occ > HIGH_OCC)) begin
            w_action = ACT_DELETE;
        end else begin
            w_action = ACT_READ;
        end
    end

    // Overflow recentres the reader HALF symbols behind the writer.
    always_comb begin
        w_rd_bin_next = r_rd_bin;
        unique case (w_action)
            ACT_OVERFLOW:         w_rd_bin_next = w_wr_bin - HALF_OCC;
            ACT_DELETE, ACT_READ: w_rd_bin_next = r_rd_bin + PW'(1);
            default:              w_rd_bin_next = r_rd_bin;
        endcase
    end

    assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FILL;
            r_rd_bin      <= '0;
            r_adj_done    <= 1'b0;
            r_gray_rd     <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_skp_added   <= 1'b0;
            r_skp_removed <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_rd_bin      <= w_rd_bin_next;
            r_gray_rd     <= w_rd_gray_next;
            r_data_valid  <= 1'b0;
            r_skp_added   <= 1'b0;
            r_skp_removed <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            unique case (w_action)
                ACT_WAIT: begin
                    r_adj_done <= 1'b0;
                end
                ACT_START: begin
                    r_adj_done <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ACT_UNDERFLOW: begin
                    r_underflow <= 1'b1;
                    r_state     <= ST_FILL;
                end
                ACT_OVERFLOW: begin
                    r_overflow <= 1'b1;
                end
                ACT_INSERT: begin
                    r_data_out   <= mem_rd_data;
                    r_data_valid <= 1'b1;
                    r_skp_added  <= 1'b1;
                    r_adj_done   <= 1'b1;
                end
                ACT_DELETE: begin
                    r_skp_removed <= 1'b1;
                    r_adj_done    <= 1'b1;
                end
                ACT_READ: begin
                    r_data_out   <= mem_rd_data;
                    r_data_valid <= 1'b1;
                    if (!w_is_skp) begin
                        r_adj_done <= 1'b0;
                    end
                end
                default: begin
                    r_adj_done <= r_adj_done;
                end
            endcase
        end
    end

    assign mem_rd_addr       = r_rd_bin[n-1:0];
    assign gray_counter_read = r_gray_rd;
    assign data_out          = r_data_out;
    assign data_valid        = r_data_valid;
    assign skp_added         = r_skp_added;
    assign skp_removed       = r_skp_removed;
    assign overflow          = r_overflow;
    assign underflow         = r_underflow;

endmodule

// File: tb/tb_elastic_buffer_read_ctrl.sv
// Randomised bench for elastic_buffer_read_ctrl: a writer model drives the gray
// write pointer and buffer contents; an integer reference model predicts every output.
module tb_elastic_buffer_read_ctrl;
    import elastic_buffer_pkg::*;

    localparam int DEPTH   = 16;
    localparam int PTR_MOD = 32;

    localparam int MODE_CTRL   = 0;
    localparam int MODE_STOP   = 1;
    localparam int MODE_DOUBLE = 2;
    localparam int MODE_RESET  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] grayWrSync;
    logic [8:0] memRdData;
    logic [3:0] memRdAddr;
    logic [4:0] grayRd;
    logic [8:0] dataOut;
    logic       dataValid;
    logic       skpAdded;
    logic       skpRemoved;
    logic       overflowFlag;
    logic       underflowFlag;

    logic [8:0] mem [DEPTH];

    int errorCount;
    int checkCount;
    int addCount, remCount, ovfCount, unfCount;

    // Reference model: integer pointers and a running/adjusted flag pair.
    int   wrPtr;
    int   mRd;
    bit   mRun;
    bit   mAdj;
    bit   eValid, eAdd, eRem, eOvf, eUnf, eDataKnown;
    logic [8:0] eData;

    elastic_buffer_read_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .gray_counter_write_sync(grayWrSync),
        .mem_rd_data            (memRdData),
        .mem_rd_addr            (memRdAddr),
        .gray_counter_read      (grayRd),
        .data_out               (dataOut),
        .data_valid             (dataValid),
        .skp_added              (skpAdded),
        .skp_removed            (skpRemoved),
        .overflow               (overflowFlag),
        .underflow              (underflowFlag)
    );

    assign memRdData = mem[memRdAddr];

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] randSym();
        logic [8:0] s;
        if ($urandom_range(0, 4) == 0) begin
            s = SKP_SYM;
        end else begin
            s = 9'($urandom_range(0, 511));
            if (s == SKP_SYM) s = 9'h0BC;
        end
        return s;
    endfunction

    task automatic writeSymbol();
        mem[wrPtr % DEPTH] = randSym();
        wrPtr = (wrPtr + 1) % PTR_MOD;
    endtask

    // Predicts the registered outputs produced by the coming clock edge.
    task automatic modelStep(input bit rstNow);
        int         occ;
        logic [8:0] head;
        eValid = 0; eAdd = 0; eRem = 0; eOvf = 0; eUnf = 0; eDataKnown = 0;
        if (rstNow) begin
            mRun = 0; mRd = 0; mAdj = 0;
            eData = 9'h000; eDataKnown = 1;
            return;
        end
        occ  = (wrPtr - mRd + PTR_MOD) % PTR_MOD;
        head = mem[mRd % DEPTH];
        if (!mRun) begin
            mAdj = 0;
            if (occ >= 8) mRun = 1;
        end else if (occ == 0) begin
            eUnf = 1;
            mRun = 0;
        end else if (occ == DEPTH) begin
            eOvf = 1;
            mRd  = (wrPtr - 8 + PTR_MOD) % PTR_MOD;
        end else if (head == SKP_SYM && !mAdj && occ < 6) begin
            eValid = 1; eData = head; eDataKnown = 1;
            eAdd = 1; mAdj = 1;
        end else if (head == SKP_SYM && !mAdj && occ > 10) begin
            eRem = 1; mAdj = 1;
            mRd  = (mRd + 1) % PTR_MOD;
        end else begin
            eValid = 1; eData = head; eDataKnown = 1;
            mRd = (mRd + 1) % PTR_MOD;
            if (head != SKP_SYM) mAdj = 0;
        end
    endtask

    task automatic applyStimulus(input int mode, input int target);
        int occ;
        int writes;
        bit doRst;
        doRst  = (mode == MODE_RESET);
        occ    = (wrPtr - mRd + PTR_MOD) % PTR_MOD;
        writes = 0;
        rst    = doRst;
        if (doRst) begin
            wrPtr = 0;
        end else if (mode == MODE_CTRL) begin
            if (occ < target - 1)   writes = 2;
            else if (occ < target)  writes = 1;
            if (mRun && $urandom_range(0, 7) == 0) writes = 0;
            if (!mRun && writes == 0) writes = 1;
            while (occ + writes > 15) writes--;
        end else if (mode == MODE_DOUBLE) begin
            writes = 2;
            while (occ + writes > DEPTH) writes--;
        end
        for (int w = 0; w < writes; w++) writeSymbol();
        grayWrSync = 5'(wrPtr ^ (wrPtr >> 1));
        modelStep(doRst);
        @(posedge clk);
        #1;
        if (skpAdded)      addCount++;
        if (skpRemoved)    remCount++;
        if (overflowFlag)  ovfCount++;
        if (underflowFlag) unfCount++;
        checkOutput("data_valid",  32'(dataValid),     32'(eValid));
        checkOutput("skp_added",   32'(skpAdded),      32'(eAdd));
        checkOutput("skp_removed", 32'(skpRemoved),    32'(eRem));
        checkOutput("overflow",    32'(overflowFlag),  32'(eOvf));
        checkOutput("underflow",   32'(underflowFlag), 32'(eUnf));
        checkOutput("mem_rd_addr", 32'(memRdAddr),     32'(mRd % DEPTH));
        checkOutput("gray_read",   32'(grayRd),        32'(mRd ^ (mRd >> 1)));
        if (eDataKnown) checkOutput("data_out", 32'(dataOut), 32'(eData));
    endtask

    task automatic runPhase(input int mode, input int target, input int len);
        for (int c = 0; c < len; c++) applyStimulus(mode, target);
    endtask

    initial begin
        errorCount = 0; checkCount = 0;
        addCount = 0; remCount = 0; ovfCount = 0; unfCount = 0;
        wrPtr = 0; mRd = 0; mRun = 0; mAdj = 0;
        eData = 9'h000;
        for (int i = 0; i < DEPTH; i++) mem[i] = 9'h000;
        rst        = 1'b1;
        grayWrSync = 5'd0;

        runPhase(MODE_RESET,  0,  3);
        runPhase(MODE_CTRL,   8,  60);
        runPhase(MODE_CTRL,   5,  200);
        runPhase(MODE_CTRL,   12, 200);
        runPhase(MODE_STOP,   0,  30);
        runPhase(MODE_CTRL,   8,  80);
        runPhase(MODE_DOUBLE, 0,  40);
        runPhase(MODE_CTRL,   8,  120);
        runPhase(MODE_RESET,  0,  1);
        runPhase(MODE_CTRL,   8,  100);

        checkOutput("seen_skp_added",   32'(addCount > 0), 32'd1);
        checkOutput("seen_skp_removed", 32'(remCount > 0), 32'd1);
        checkOutput("seen_overflow",    32'(ovfCount > 0), 32'd1);
        checkOutput("seen_underflow",   32'(unfCount > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
